// File: rtl/march_pkg.sv
// Shared definitions for the March C- command generator: command modes,
// element op table, FSM state type and the command word packer.
package march_pkg;

  localparam logic [6:0] WR_MODE   = 7'h02;
  localparam logic [6:0] RD_MODE   = 7'h03;
  localparam int         NUM_ELEMS = 6;
  localparam logic [2:0] LAST_ELEM = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Per-element description: number of ops (1 or 2), walk direction,
  // per-op read flag and per-op data polarity (1 = inverted background).
  // Bit [0] of rd/inv describes the first op, bit [1] the second op.
  typedef struct packed {
    logic [1:0] n_ops;
    logic       down;
    logic [1:0] rd;
    logic [1:0] inv;
  } elem_cfg_t;

  // March C- op table: M0 w0 | M1 r0 w1 | M2 r1 w0 | M3 r0 w1 | M4 r1 w0 | M5 r0
  function automatic elem_cfg_t elem_cfg(input logic [2:0] e);
    elem_cfg_t c;
    case (e)
      3'd0:    c = '{n_ops: 2'd1, down: 1'b0, rd: 2'b00, inv: 2'b00};
      3'd1:    c = '{n_ops: 2'd2, down: 1'b0, rd: 2'b01, inv: 2'b10};
      3'd2:    c = '{n_ops: 2'd2, down: 1'b0, rd: 2'b01, inv: 2'b01};
      3'd3:    c = '{n_ops: 2'd2, down: 1'b1, rd: 2'b01, inv: 2'b10};
      3'd4:    c = '{n_ops: 2'd2, down: 1'b1, rd: 2'b01, inv: 2'b01};
      3'd5:    c = '{n_ops: 2'd1, down: 1'b0, rd: 2'b01, inv: 2'b00};
      default: c = '{n_ops: 2'd0, down: 1'b0, rd: 2'b00, inv: 2'b00};
    endcase
    return c;
  endfunction

  // Command word {flag, mode, addr, data}; writes never carry the flag.
  function automatic logic [31:0] make_cmd(input logic        rd,
                                           input logic        flag,
                                           input logic [15:0] addr,
                                           input logic [7:0]  data);
    logic [31:0] w;
    if (rd) begin
      w = {flag, RD_MODE, addr, data};
    end else begin
      w = {1'b0, WR_MODE, addr, data};
    end
    return w;
  endfunction

endpackage

// File: rtl/march_addr_cnt.sv
// Loadable up/down 16-bit address counter. 'last' marks the final address
// of the current walk direction (ADDR_MAX going up, 0 going down), so the
// element end is found by compare rather than by wrap-around.
module march_addr_cnt #(
  parameter logic [15:0] ADDR_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  input  logic        down,
  output logic [15:0] addr,
  output logic        last
);

  // Address register: clear has priority over load, load over step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= 16'd0;
    end else if (clr) begin
      addr <= 16'd0;
    end else if (load) begin
      addr <= load_val;
    end else if (step) begin
      addr <= down ? (addr - 16'd1) : (addr + 16'd1);
    end else begin
      addr <= addr;
    end
  end

  // End-of-walk flag for the current direction.
  always_comb begin
    last = 1'b0;
    if (down) begin
      last = (addr == 16'd0);
    end else begin
      last = (addr == ADDR_MAX);
    end
  end

endmodule

// File: rtl/march_cmd_gen.sv
// March C- command generator: walks six March elements over 0..ADDR_MAX and
// emits one registered write/read command per issue slot, with GAP idle
// cycles after each command.
module march_cmd_gen
  import march_pkg::*;
#(
  parameter logic [15:0] ADDR_MAX = 16'hFFFF,
  parameter int          GAP      = 0
) (
  input  logic        core_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  pattern,
  input  logic        inv_en,
  output logic [31:0] dut_data,
  output logic        dut_valid,
  output logic        busy,
  output logic        done,
  output logic [2:0]  elem_idx
);

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t      state_r, state_n;
  logic [2:0]  elem_r, elem_n;
  logic        op_r, op_n;
  logic [3:0]  gap_cnt_r, gap_cnt_n;
  logic        last_r, last_n;
  logic [7:0]  pat_r;
  logic        inv_r;
  logic        accept;

  logic        cnt_clr, cnt_load, cnt_step;
  logic [15:0] addr;
  logic        addr_last;

  elem_cfg_t   cfg, next_cfg;
  logic        op_last, cmd_last, cur_rd;
  logic [7:0]  cur_data;
  logic [31:0] cmd_word;

  logic        valid_n, done_n, busy_n;
  logic [31:0] data_n;
  logic [2:0]  elem_idx_n;

  march_addr_cnt #(.ADDR_MAX(ADDR_MAX)) u_addr_cnt (
    .clk      (core_clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (next_cfg.down ? ADDR_MAX : 16'd0),
    .step     (cnt_step),
    .down     (cfg.down),
    .addr     (addr),
    .last     (addr_last)
  );

  // Decode of the op currently pointed at by element/op/address.
  always_comb begin
    cfg      = elem_cfg(elem_r);
    next_cfg = elem_cfg(elem_r + 3'd1);
    op_last  = ({1'b0, op_r} == (cfg.n_ops - 2'd1));
    cmd_last = op_last && addr_last && (elem_r == LAST_ELEM);
    cur_rd   = cfg.rd[op_r];
    cur_data = cfg.inv[op_r] ? ~pat_r : pat_r;
    cmd_word = make_cmd(cur_rd, inv_r, addr, cur_data);
  end

  // Next-state, sequencing and next-output logic.
  always_comb begin
    state_n    = state_r;
    elem_n     = elem_r;
    op_n       = op_r;
    gap_cnt_n  = gap_cnt_r;
    last_n     = last_r;
    accept     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    valid_n    = 1'b0;
    data_n     = 32'd0;
    done_n     = 1'b0;
    busy_n     = 1'b0;
    elem_idx_n = elem_idx;

    if ((state_r != ST_IDLE) && abort) begin
      // Abort: drop everything, no done, no further commands.
      state_n    = ST_IDLE;
      elem_n     = 3'd0;
      op_n       = 1'b0;
      gap_cnt_n  = 4'd0;
      last_n     = 1'b0;
      cnt_clr    = 1'b1;
      elem_idx_n = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            state_n    = ST_ISSUE;
            accept     = 1'b1;
            elem_n     = 3'd0;
            op_n       = 1'b0;
            last_n     = 1'b0;
            cnt_clr    = 1'b1;
            elem_idx_n = 3'd0;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          valid_n    = 1'b1;
          data_n     = cmd_word;
          busy_n     = 1'b1;
          elem_idx_n = elem_r;
          last_n     = cmd_last;
          gap_cnt_n  = 4'd0;
          if (!op_last) begin
            op_n = 1'b1;
          end else begin
            op_n = 1'b0;
            if (cmd_last) begin
              cnt_clr = 1'b1;
              elem_n  = 3'd0;
            end else if (addr_last) begin
              cnt_load = 1'b1;
              elem_n   = elem_r + 3'd1;
            end else begin
              cnt_step = 1'b1;
            end
          end
          if (GAP > 0) begin
            state_n = ST_GAP;
          end else if (cmd_last) begin
            state_n = ST_FIN;
          end else begin
            state_n = ST_ISSUE;
          end
        end
        ST_GAP: begin
          busy_n = 1'b1;
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_n = 4'd0;
            state_n   = last_r ? ST_FIN : ST_ISSUE;
          end else begin
            gap_cnt_n = gap_cnt_r + 4'd1;
          end
        end
        ST_FIN: begin
          busy_n  = 1'b1;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Control state registers and run-time latches of pattern/inv_en.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      elem_r    <= 3'd0;
      op_r      <= 1'b0;
      gap_cnt_r <= 4'd0;
      last_r    <= 1'b0;
      pat_r     <= 8'd0;
      inv_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      elem_r    <= elem_n;
      op_r      <= op_n;
      gap_cnt_r <= gap_cnt_n;
      last_r    <= last_n;
      if (accept) begin
        pat_r <= pattern;
        inv_r <= inv_en;
      end else begin
        pat_r <= pat_r;
        inv_r <= inv_r;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      dut_data  <= 32'd0;
      dut_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      elem_idx  <= 3'd0;
    end else begin
      dut_data  <= data_n;
      dut_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
      elem_idx  <= elem_idx_n;
    end
  end

endmodule

// File: tb/tb_march_cmd_gen.sv
// Self-checking bench for march_cmd_gen: a behavioural March C- model fills a
// scoreboard with {cycle, word, element}; the monitor pops and compares.
module tb_march_cmd_gen;

  logic        core_clk = 1'b0;
  logic        rst      = 1'b1;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [7:0]  pattern  = 8'h00;
  logic        inv_en   = 1'b0;

  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
  logic [2:0]  a_elem, b_elem;

  march_cmd_gen #(.ADDR_MAX(16'd3), .GAP(0)) u_a (
    .core_clk(core_clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .inv_en(inv_en), .dut_data(a_data),
    .dut_valid(a_valid), .busy(a_busy), .done(a_done), .elem_idx(a_elem));

  march_cmd_gen #(.ADDR_MAX(16'd1), .GAP(2)) u_b (
    .core_clk(core_clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .inv_en(inv_en), .dut_data(b_data),
    .dut_valid(b_valid), .busy(b_busy), .done(b_done), .elem_idx(b_elem));

  always #5 core_clk = ~core_clk;

  logic        sel = 1'b0;
  logic [31:0] o_data;
  logic        o_valid, o_busy, o_done;
  logic [2:0]  o_elem;
  assign o_data  = sel ? b_data  : a_data;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_elem  = sel ? b_elem  : a_elem;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [2:0]  elem;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] cap [0:127];
  int          done_at;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural March C- model: one op string per element.
  task automatic build(input int am, input int gap, input logic [7:0] p, input logic inv);
    string       ops[6];
    int          k;
    int          a;
    byte         c0, c1;
    logic        rd;
    logic [7:0]  v;
    logic [15:0] a16;
    logic [31:0] w;
    ops = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    sb.delete();
    k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i <= am; i++) begin
        a   = (e == 3 || e == 4) ? (am - i) : i;
        a16 = 16'(a);
        for (int j = 0; j < ops[e].len(); j += 2) begin
          c0 = ops[e][j];
          c1 = ops[e][j+1];
          rd = (c0 == 8'h72);
          v  = (c1 == 8'h31) ? ~p : p;
          w  = rd ? {inv, 7'h03, a16, v} : {1'b0, 7'h02, a16, v};
          sb.push_back('{cyc: 1 + k * (gap + 1), data: w, elem: 3'(e)});
          k++;
        end
      end
    end
  endtask

  // One run: start at cycle 0, optional abort/restart pulses, per-cycle checks.
  task automatic run(input int am, input int gap, input logic [7:0] p, input logic inv,
                     input int abort_at, input int restart_at);
    int  last_cyc, done_cyc, end_cyc;
    logic exp_v;
    build(am, gap, p, inv);
    last_cyc = 1 + (10 * (am + 1) - 1) * (gap + 1);
    done_cyc = (abort_at > 0) ? -1 : last_cyc + gap + 1;
    end_cyc  = (abort_at > 0) ? abort_at + 20 : done_cyc + 1;
    if (abort_at > 0) begin
      while (sb.size() > 0 && sb[sb.size()-1].cyc > abort_at) begin
        void'(sb.pop_back());
      end
    end
    done_at = -1;
    @(negedge core_clk);
    pattern = p; inv_en = inv; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0; pattern = ~p; inv_en = ~inv;
    for (int cyc = 1; cyc <= end_cyc; cyc++) begin
      @(negedge core_clk);
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk($sformatf("valid c%0d", cyc), {31'd0, o_valid}, {31'd0, exp_v});
      if (exp_v) begin
        chk($sformatf("data c%0d", cyc), o_data, sb[0].data);
        chk($sformatf("elem c%0d", cyc), {29'd0, o_elem}, {29'd0, sb[0].elem});
        void'(sb.pop_front());
      end else begin
        chk($sformatf("idle data c%0d", cyc), o_data, 32'd0);
      end
      chk($sformatf("done c%0d", cyc), {31'd0, o_done}, {31'd0, (cyc == done_cyc)});
      chk($sformatf("busy c%0d", cyc), {31'd0, o_busy},
          {31'd0, (abort_at > 0) ? (cyc <= abort_at) : (cyc <= done_cyc)});
      if (o_done) done_at = cyc;
      if (cyc < 128) cap[cyc] = o_data;
      abort = (abort_at > 0) && (cyc == abort_at);
      start = (restart_at > 0) && (cyc == restart_at);
    end
    abort = 1'b0;
    start = 1'b0;
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{cyc: 1,  data: 32'h0200005A};
    tbl[1] = '{cyc: 2,  data: 32'h0200015A};
    tbl[2] = '{cyc: 3,  data: 32'h0200025A};
    tbl[3] = '{cyc: 4,  data: 32'h0200035A};
    tbl[4] = '{cyc: 5,  data: 32'h0300005A};
    tbl[5] = '{cyc: 6,  data: 32'h020000A5};
    tbl[6] = '{cyc: 40, data: 32'h0300035A};

    // Reset values
    idle(2);
    chk("rst data", a_data, 32'd0);
    chk("rst valid", {31'd0, a_valid}, 32'd0);
    chk("rst busy", {31'd0, a_busy}, 32'd0);
    chk("rst done", {31'd0, a_done}, 32'd0);
    chk("rst elem", {29'd0, a_elem}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Basic run, ADDR_MAX=3, GAP=0
    sel = 1'b0;
    run(3, 0, 8'h5A, 1'b0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("table c%0d", tbl[i].cyc), cap[tbl[i].cyc], tbl[i].data);
    end
    chk("done cycle A", 32'(done_at), 32'd41);
    idle(30);

    // Readback inversion flag on reads only
    run(3, 0, 8'h5A, 1'b1, 0, 0);
    chk("inv M3 first", cap[21], 32'h8300035A);
    idle(30);

    // GAP=2, ADDR_MAX=1
    sel = 1'b1;
    run(1, 2, 8'h3C, 1'b0, 0, 0);
    chk("done cycle B", 32'(done_at), 32'd61);
    idle(5);

    // Abort in cycle 10, then fresh start
    sel = 1'b0;
    run(3, 0, 8'h5A, 1'b0, 10, 0);
    chk("abort no done", done_at, -1);
    idle(5);
    run(3, 0, 8'h5A, 1'b0, 0, 0);
    chk("restart first cmd", cap[1], 32'h0200005A);
    idle(30);

    // Start while busy is ignored
    run(3, 0, 8'h5A, 1'b0, 0, 5);
    idle(30);

    // Abort together with start in IDLE: nothing begins
    @(negedge core_clk);
    start = 1'b1; abort = 1'b1;
    @(negedge core_clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("abort+start valid", {31'd0, a_valid}, 32'd0);
      chk("abort+start busy", {31'd0, a_busy}, 32'd0);
      @(negedge core_clk);
    end

    // Reset mid-run
    @(negedge core_clk);
    pattern = 8'h5A; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    idle(9);
    chk("pre-reset busy", {31'd0, a_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst data", a_data | b_data, 32'd0);
    chk("mid rst flags", {26'd0, a_valid, b_valid, a_busy, b_busy, a_done, b_done}, 32'd0);
    chk("mid rst elem", {26'd0, a_elem, b_elem}, 32'd0);
    @(negedge core_clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      chk("post rst idle", {27'd0, a_valid, a_busy, a_done, b_valid, b_busy}, 32'd0);
    end
    run(3, 0, 8'h5A, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/march_cmd_gen.md
# march_cmd_gen

Upstream command source for the memory-under-test interface. On a start pulse it walks a March C- algorithm over a configurable address range and emits one 32-bit write or read command per issue slot on `dut_data`/`dut_valid`. Its output wires directly to the `dut_data`/`dut_valid` inputs of the memory interface stage. Read commands carry the expected byte in `[7:0]`; the memory stage ignores that field for reads, and the downstream checker uses it.

## Interface
- `ADDR_MAX`, 16'hFFFF: last address tested; the range is 0..ADDR_MAX.
- `GAP`, 0: idle cycles inserted after every command (0–15).
- `core_clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run when idle.
- `abort`  in  1  synchronous stop; returns to idle.
- `pattern`  in  8  background byte ("0" = pattern, "1" = ~pattern).
- `inv_en`  in  1  sets bit 31 on read commands (readback inversion).
- `dut_data`  out  32  command word.
- `dut_valid`  out  1  command strobe, high for one cycle per command.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `elem_idx`  out  3  current March element, 0–5.

## Operation
- Command format: `{flag, mode[6:0], addr[15:0], data[7:0]}`.
  - Write: flag=0, mode=7'h02, data = value written.
  - Read: flag=inv_en, mode=7'h03, data = expected value.
- March C- elements, with ops issued in order per address:
  - M0 up: w0
  - M1 up: r0, w1
  - M2 up: r1, w0
  - M3 down: r0, w1
  - M4 down: r1, w0
  - M5 up: r0
- Direction: "up" runs addresses 0→ADDR_MAX; "down" runs ADDR_MAX→0. End-of-element is detected by address compare, never by counter carry, so ADDR_MAX=16'hFFFF works. ADDR_MAX=0 gives one address per element.
- Command count: 10·(ADDR_MAX+1) per run.
- `pattern` and `inv_en` are latched on accepted `start`. Later changes during a run have no effect.
- FSM states:
  - IDLE: `start` → ISSUE.
  - ISSUE: drive one command, advance op/addr/element. Go to GAP if GAP>0. Otherwise stay in ISSUE, or go to FIN after the last command.
  - GAP: count GAP cycles, then go to ISSUE, or to FIN after the last command.
  - FIN: assert `done` for one cycle → IDLE.
- `start` while busy is ignored.
- `abort` in any non-IDLE state → IDLE on the next edge. No `done`, and no further `dut_valid`. `abort` and `start` together in IDLE: `abort` wins and no run begins.
- Reset mid-run: all state and outputs clear immediately; no `done`.

## Timing
- Reset values:
  - `dut_data`=0, `dut_valid`=0, `busy`=0, `done`=0, `elem_idx`=0.
  - FSM in IDLE; address and op counters at 0.
- All outputs are registered.
- Command k (0-based) has `dut_valid` high in cycle 1+k·(GAP+1), where cycle 0 is the edge that samples `start`.
- `dut_data` holds its value only while `dut_valid`=1; it is 0 otherwise.
- `done` rises in the cycle (last command cycle)+GAP+1.
- `busy` is high from cycle 1 through the `done` cycle inclusive, and low the cycle after.
- A new `start` is accepted in the cycle after `done`.
- `elem_idx` changes in the cycle the element's first command is driven.
- There is no backpressure. The downstream stage accepts one command per cycle.

## Structure
- Shared package `march_pkg` holds:
  - `WR_MODE`=7'h02, `RD_MODE`=7'h03.
  - Element count (6), and an op table per element: op count, direction, and per op rd/wr plus data polarity.
  - FSM state typedef.
- One sub-module, `march_addr_cnt`: a loadable up/down 16-bit counter with `last` flag (addr==ADDR_MAX going up, addr==0 going down).

## Test plan
- ADDR_MAX=3, GAP=0, pattern=8'h5A, inv_en=0, start:
  - Cycles 1–4 carry 0x0200005A, 0x0200015A, 0x0200025A, 0x0200035A.
  - Cycle 5 = 0x0300005A, cycle 6 = 0x020000A5.
  - 40 commands total, `done` in cycle 41, `busy` low in cycle 42.
- Same setup with inv_en=1:
  - Command 20 (cycle 21, M3 first) = 0x8300035A.
  - No write command has bit 31 set.
- GAP=2, ADDR_MAX=1:
  - `dut_valid` in cycles 1, 4, 7, …; 20 commands.
  - `done` in cycle 1+19·3+3 = 61.
- `abort` in cycle 10:
  - No `dut_valid` from cycle 11 on, `busy`=0 in cycle 11, no `done`.
  - A fresh `start` restarts at 0x0200005A.
- `start` pulsed again in cycle 5 of a run: ignored, and the command sequence is unchanged.
- `rst` asserted mid-run: all outputs 0 immediately; after release, IDLE until `start`.
